// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the pushbutton conditioning front end.
// Holds the per-channel debounce state encodings used by key_debounce_ch.
package key_pulse_gen_pkg;

    typedef enum logic [1:0] {
        KP_IDLE         = 2'd0,
        KP_PRESS_WAIT   = 2'd1,
        KP_PRESSED      = 2'd2,
        KP_RELEASE_WAIT = 2'd3
    } kp_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM with run counter,
// and registered one-cycle press pulse.
//   clk      global clock
//   rst      synchronous, active-high reset
//   pb_in    raw pushbutton, active-low (0 = pressed)
//   pulse_n  one-cycle active-low pulse on each accepted press
//   pressed  debounced held level, active-high
//
// state           | meaning
// ----------------+-----------------------------------------------
// KP_IDLE         | released and stable
// KP_PRESS_WAIT   | low samples seen, counting toward acceptance
// KP_PRESSED      | press accepted, button held
// KP_RELEASE_WAIT | high samples seen, counting toward release
module key_debounce_ch
    import key_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pulse_n,
    output logic pressed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q1;
    logic             sync_q2;
    kp_state_t        state;
    kp_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             fire;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fire      = 1'b0;
        case (state)
            KP_IDLE: begin
                if (!sync_q2) begin
                    state_nxt = KP_PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            KP_PRESS_WAIT: begin
                if (sync_q2) begin
                    state_nxt = KP_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = KP_PRESSED;
                    cnt_nxt   = '0;
                    fire      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            KP_PRESSED: begin
                if (sync_q2) begin
                    state_nxt = KP_RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            KP_RELEASE_WAIT: begin
                // A low sample here is release bounce: return to held, no pulse.
                if (!sync_q2) begin
                    state_nxt = KP_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = KP_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = KP_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            state   <= KP_IDLE;
            cnt     <= '0;
            pulse_n <= 1'b1;
            pressed <= 1'b0;
        end else begin
            sync_q1 <= pb_in;
            sync_q2 <= sync_q1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pulse_n <= ~fire;
            // Registered from the next state so it lines up with the state register.
            pressed <= (state_nxt == KP_PRESSED) || (state_nxt == KP_RELEASE_WAIT);
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// Conditions two raw active-low bouncing pushbuttons into clean one-cycle
// active-low pulses for the 12/24-hour mode FSM. Channels are independent.
//   clk      global clock
//   rst      synchronous, active-high reset
//   pb_in    raw pushbuttons, active-low; bit0 -> in1, bit1 -> in2
//   pulse_n  registered one-cycle active-low press pulses
//   pressed  registered debounced held level, active-high
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pb_in,
    output logic [1:0] pulse_n,
    output logic [1:0] pressed
);

    for (genvar i = 0; i < 2; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .pb_in   (pb_in[i]),
            .pulse_n (pulse_n[i]),
            .pressed (pressed[i])
        );
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
module tb_key_pulse_gen;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pb_in = 2'b11;
    logic [1:0] pulse_n;
    logic [1:0] pressed;

    key_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .pb_in   (pb_in),
        .pulse_n (pulse_n),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: debounced level plus length of the current run of
    // samples disagreeing with it; two-deep delay line for the synchroniser.
    logic [1:0] m_d1, m_d2;
    logic [1:0] m_lvl;
    int         m_run [2];
    logic [1:0] exp_pulse_n, exp_pressed;

    int pcnt [2];
    int seg_cyc;
    int first_idx [2];
    int both_idx;

    task automatic model_step(input logic [1:0] pb, input logic r);
        logic [1:0] fire;
        fire = 2'b00;
        if (r) begin
            m_d1 = 2'b11; m_d2 = 2'b11; m_lvl = 2'b00;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                // disagreeing sample: low while released, or high while held
                if ((m_lvl[c] == 1'b0 && m_d2[c] == 1'b0) ||
                    (m_lvl[c] == 1'b1 && m_d2[c] == 1'b1)) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        m_lvl[c] = ~m_lvl[c];
                        m_run[c] = 0;
                        fire[c]  = m_lvl[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = pb;
        end
        exp_pulse_n = ~fire;
        exp_pressed = m_lvl;
    endtask

    task automatic seg_start();
        pcnt[0] = 0; pcnt[1] = 0;
        first_idx[0] = -1; first_idx[1] = -1; both_idx = -1;
        seg_cyc = 0;
    endtask

    task automatic step(input logic [1:0] pb, input logic r);
        pb_in = pb;
        rst   = r;
        @(posedge clk);
        model_step(pb, r);
        #1;
        vectors++;
        assert (pulse_n === exp_pulse_n) else begin
            miscompares++;
            $error("FAIL pulse_n cyc=%0d observed=%b expected=%b", seg_cyc, pulse_n, exp_pulse_n);
        end
        vectors++;
        assert (pressed === exp_pressed) else begin
            miscompares++;
            $error("FAIL pressed cyc=%0d observed=%b expected=%b", seg_cyc, pressed, exp_pressed);
        end
        for (int c = 0; c < 2; c++) begin
            if (pulse_n[c] === 1'b0) begin
                pcnt[c]++;
                if (first_idx[c] < 0) first_idx[c] = seg_cyc;
            end
        end
        if (pulse_n === 2'b00 && both_idx < 0) both_idx = seg_cyc;
        seg_cyc++;
    endtask

    task automatic repeat_step(input logic [1:0] pb, input int n);
        for (int k = 0; k < n; k++) step(pb, 1'b0);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        int hold [2];
        logic [1:0] pbr;

        // reset
        seg_start();
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);
        vectors++;
        assert (pulse_n === 2'b11 && pressed === 2'b00) else begin
            miscompares++;
            $error("FAIL reset_state observed=%b/%b expected=11/00", pulse_n, pressed);
        end
        repeat_step(2'b11, 3);

        // clean press on bit0, first sampling edge is step 0
        seg_start();
        repeat_step(2'b10, 20);
        check_int("clean_latency", first_idx[0], 5);
        check_int("clean_pulses0", pcnt[0], 1);
        check_int("clean_pulses1", pcnt[1], 0);
        seg_start();
        repeat_step(2'b11, 20);
        check_int("clean_release_pulses", pcnt[0], 0);

        // press bounce then a stable press
        seg_start();
        step(2'b10, 1'b0); step(2'b11, 1'b0); step(2'b10, 1'b0); step(2'b11, 1'b0);
        repeat_step(2'b11, 10);
        check_int("press_bounce_pulses", pcnt[0], 0);
        repeat_step(2'b10, 8);
        check_int("press_after_bounce", pcnt[0], 1);

        // release bounce from PRESSED
        seg_start();
        repeat_step(2'b11, 2);
        repeat_step(2'b10, 3);
        repeat_step(2'b11, 10);
        check_int("release_bounce_pulses", pcnt[0], 0);
        vectors++;
        assert (pressed[0] === 1'b0) else begin
            miscompares++;
            $error("FAIL release_final observed=%b expected=0", pressed[0]);
        end

        // simultaneous press
        seg_start();
        repeat_step(2'b00, 10);
        check_int("simul_latency", both_idx, 5);
        vectors++;
        assert (pressed === 2'b11) else begin
            miscompares++;
            $error("FAIL simul_pressed observed=%b expected=11", pressed);
        end
        repeat_step(2'b11, 10);

        // reset during PRESS_WAIT, button held through reset release
        repeat_step(2'b10, 3);
        step(2'b10, 1'b1);
        vectors++;
        assert (pulse_n === 2'b11 && pressed === 2'b00) else begin
            miscompares++;
            $error("FAIL rst_pw observed=%b/%b expected=11/00", pulse_n, pressed);
        end
        seg_start();
        repeat_step(2'b10, 10);
        check_int("rst_pw_latency", first_idx[0], 5);
        check_int("rst_pw_pulses", pcnt[0], 1);

        // reset during PRESSED
        step(2'b10, 1'b1);
        vectors++;
        assert (pulse_n === 2'b11 && pressed === 2'b00) else begin
            miscompares++;
            $error("FAIL rst_pressed observed=%b/%b expected=11/00", pulse_n, pressed);
        end
        seg_start();
        repeat_step(2'b10, 10);
        check_int("rst_pressed_latency", first_idx[0], 5);
        repeat_step(2'b11, 10);

        // long hold on bit1
        seg_start();
        repeat_step(2'b01, 100);
        check_int("long_pulses1", pcnt[1], 1);
        check_int("long_pulses0", pcnt[0], 0);
        repeat_step(2'b11, 10);

        // randomized bouncing with occasional reset
        hold[0] = 0; hold[1] = 0;
        pbr = 2'b11;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    pbr[c]  = ~pbr[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12)
                                                          : $urandom_range(1, 5);
                end
                hold[c]--;
            end
            step(pbr, ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
